// File: rtl/shift_reg_pkg.sv
// Shared definitions for the multi-lane shift register: mode encodings and helpers.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } shift_mode_e;

    // Both shift directions advance the shared word counter.
    function automatic logic mode_is_shift(shift_mode_e m);
        return (m == MODE_SHL) || (m == MODE_SHR);
    endfunction

endpackage

// File: rtl/shift_reg_lane.sv
// One lane of shift_reg_lanes: lane register, serial-out bit and, when
// SHREG_DETECT_EN is defined, a registered pattern-match flag.
module shift_reg_lane
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             d_i,
    input  logic [WIDTH-1:0] load_data_i,
`ifdef SHREG_DETECT_EN
    input  logic [WIDTH-1:0] pattern_i,
    output logic             match_o,
`endif
    output logic [WIDTH-1:0] out_o,
    output logic             sout_o
);

    shift_mode_e      mode;
    logic [WIDTH-1:0] lane_q, lane_d;
    logic             sout_q, sout_d;

    assign mode = shift_mode_e'(mode_i);

    always_comb begin
        lane_d = lane_q;
        sout_d = sout_q;
        if (en_i) begin
            unique case (mode)
                MODE_SHL: begin
                    lane_d = {lane_q[WIDTH-2:0], d_i};
                    sout_d = lane_q[WIDTH-1];
                end
                MODE_SHR: begin
                    lane_d = {d_i, lane_q[WIDTH-1:1]};
                    sout_d = lane_q[0];
                end
                MODE_LOAD: lane_d = load_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            sout_q <= 1'b0;
        end else begin
            lane_q <= lane_d;
            sout_q <= sout_d;
        end
    end

    assign out_o  = lane_q;
    assign sout_o = sout_q;

`ifdef SHREG_DETECT_EN
    // Compare against the next lane value so match lines up with out_o.
    logic match_q, match_d;

    assign match_d = (lane_d == pattern_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match_o = match_q;
`endif

endmodule

// File: rtl/shift_reg_lanes.sv
// Multi-lane bidirectional shift register with parallel load and a shared
// word counter. Optional pattern detection is enabled by SHREG_DETECT_EN.
module shift_reg_lanes
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LANES = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic [1:0]             mode_i,
    input  logic [LANES-1:0]       d_i,
    input  logic [LANES*WIDTH-1:0] load_data_i,
`ifdef SHREG_DETECT_EN
    input  logic [WIDTH-1:0]       pattern_i,
    output logic [LANES-1:0]       match_o,
`endif
    output logic [LANES*WIDTH-1:0] out_o,
    output logic [LANES-1:0]       sout_o,
    output logic                   word_valid_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    shift_mode_e      mode;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             word_valid_q, word_valid_d;

    assign mode = shift_mode_e'(mode_i);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        shift_reg_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .en_i        (en_i),
            .mode_i      (mode_i),
            .d_i         (d_i[l]),
            .load_data_i (load_data_i[l*WIDTH +: WIDTH]),
`ifdef SHREG_DETECT_EN
            .pattern_i   (pattern_i),
            .match_o     (match_o[l]),
`endif
            .out_o       (out_o[l*WIDTH +: WIDTH]),
            .sout_o      (sout_o[l])
        );
    end

    // The WIDTH-th shift wraps the counter straight to 0, so back-to-back
    // words pulse word_valid every WIDTH shifts with no dead cycle.
    always_comb begin
        cnt_d        = cnt_q;
        word_valid_d = 1'b0;
        if (en_i) begin
            if (mode == MODE_LOAD) begin
                cnt_d = '0;
            end else if (mode_is_shift(mode)) begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d        = '0;
                    word_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_valid_o = word_valid_q;

endmodule

// File: tb/tb_shift_reg_lanes.sv
// Bench for shift_reg_lanes: a 4x1 and an 8x3 instance share en/mode and are
// checked every cycle against an arithmetic reference model.
module tb_shift_reg_lanes;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic        a_d;
    logic [3:0]  a_load;
    logic [3:0]  a_out;
    logic        a_sout;
    logic        a_wv;
    logic [2:0]  b_d;
    logic [23:0] b_load;
    logic [23:0] b_out;
    logic [2:0]  b_sout;
    logic        b_wv;
    logic [3:0]  a_pat;
    logic [7:0]  b_pat;
`ifdef SHREG_DETECT_EN
    logic        a_match;
    logic [2:0]  b_match;
`endif

    int tests;
    int fails;

    // Reference model state, index 0 = 4x1 instance, 1 = 8x3 instance.
    int unsigned m_val   [2][3];
    bit          m_sout  [2][3];
    bit          m_match [2][3];
    int          m_shifts[2];
    bit          m_wv    [2];

    shift_reg_lanes #(.WIDTH(4), .LANES(1)) u_dut_a (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .mode_i       (mode),
        .d_i          (a_d),
        .load_data_i  (a_load),
`ifdef SHREG_DETECT_EN
        .pattern_i    (a_pat),
        .match_o      (a_match),
`endif
        .out_o        (a_out),
        .sout_o       (a_sout),
        .word_valid_o (a_wv)
    );

    shift_reg_lanes #(.WIDTH(8), .LANES(3)) u_dut_b (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .en_i         (en),
        .mode_i       (mode),
        .d_i          (b_d),
        .load_data_i  (b_load),
`ifdef SHREG_DETECT_EN
        .pattern_i    (b_pat),
        .match_o      (b_match),
`endif
        .out_o        (b_out),
        .sout_o       (b_sout),
        .word_valid_o (b_wv)
    );

    // Clock: posedges at 10, 20, 30 ... ns.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int l = 0; l < 3; l++) begin
                m_val[k][l]   = 0;
                m_sout[k][l]  = 0;
                m_match[k][l] = 0;
            end
            m_shifts[k] = 0;
            m_wv[k]     = 0;
        end
    endtask

    // Lane value as an integer in [0, 2**w); shifts are *2 / div 2 arithmetic.
    task automatic model_edge(int k, int w, int nl, bit e, bit [1:0] md,
                              bit [2:0] dv, bit [23:0] ldv, int unsigned pat);
        int unsigned span;
        int unsigned top;
        span = 1 << w;
        top  = 1 << (w - 1);
        m_wv[k] = 0;
        for (int l = 0; l < nl; l++) begin
            if (e && md == 2'd1) begin
                m_sout[k][l] = (m_val[k][l] / top) % 2 == 1;
                m_val[k][l]  = (m_val[k][l] * 2 + int'(dv[l])) % span;
            end else if (e && md == 2'd2) begin
                m_sout[k][l] = m_val[k][l] % 2 == 1;
                m_val[k][l]  = m_val[k][l] / 2 + int'(dv[l]) * top;
            end else if (e && md == 2'd3) begin
                m_val[k][l] = (int'(ldv) >> (l * w)) % span;
            end
            m_match[k][l] = (m_val[k][l] == pat);
        end
        if (e && (md == 2'd1 || md == 2'd2)) begin
            m_shifts[k]++;
            if (m_shifts[k] == w) begin
                m_shifts[k] = 0;
                m_wv[k]     = 1;
            end
        end else if (e && md == 2'd3) begin
            m_shifts[k] = 0;
        end
    endtask

    function automatic logic [31:0] exp_out(int k, int w, int nl);
        logic [31:0] r;
        r = '0;
        for (int l = 0; l < nl; l++) r = r | (32'(m_val[k][l]) << (l * w));
        return r;
    endfunction

    function automatic logic [31:0] exp_bits(int k, int nl, bit sel_match);
        logic [31:0] r;
        r = '0;
        for (int l = 0; l < nl; l++) r[l] = sel_match ? m_match[k][l] : m_sout[k][l];
        return r;
    endfunction

    task automatic check_all(string tag);
        chk({tag, "/a_out"},  32'(a_out),  exp_out(0, 4, 1));
        chk({tag, "/a_sout"}, 32'(a_sout), exp_bits(0, 1, 0));
        chk({tag, "/a_wv"},   32'(a_wv),   32'(m_wv[0]));
        chk({tag, "/b_out"},  32'(b_out),  exp_out(1, 8, 3));
        chk({tag, "/b_sout"}, 32'(b_sout), exp_bits(1, 3, 0));
        chk({tag, "/b_wv"},   32'(b_wv),   32'(m_wv[1]));
`ifdef SHREG_DETECT_EN
        chk({tag, "/a_match"}, 32'(a_match), exp_bits(0, 1, 1));
        chk({tag, "/b_match"}, 32'(b_match), exp_bits(1, 3, 1));
`endif
    endtask

    // Drive one cycle: instance A gets directed data, B gets random data.
    task automatic step(string tag, bit e, bit [1:0] md, bit a_dv, bit [3:0] a_ldv);
        bit [2:0]  b_dv;
        bit [23:0] b_ldv;
        b_dv   = 3'($urandom_range(0, 7));
        b_ldv  = 24'($urandom());
        en     = e;
        mode   = md;
        a_d    = a_dv;
        a_load = a_ldv;
        b_d    = b_dv;
        b_load = b_ldv;
        @(posedge clk);
        model_edge(0, 4, 1, e, md, {2'b00, a_dv}, {20'd0, a_ldv}, int'(a_pat));
        model_edge(1, 8, 3, e, md, b_dv, b_ldv, int'(b_pat));
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        mode   = 2'b00;
        a_d    = 1'b0;
        a_load = '0;
        b_d    = '0;
        b_load = '0;
        a_pat  = 4'b1111;
        b_pat  = 8'hA5;
        model_reset();

        #22;
        check_all("reset");
        #3;
        rst_n = 1'b1;

        // Serial fill, left shift: two zeros then ones.
        step("shl0", 1, 2'd1, 0, 4'h0);
        step("shl1", 1, 2'd1, 0, 4'h0);
        for (int i = 0; i < 4; i++) step("shl_ones", 1, 2'd1, 1, 4'h0);
        chk("fill_value", 32'(a_out), 32'h0000_000F);

        // Load then right shift with zeros; sout walks 0,1,0,1.
        step("load_1010", 1, 2'd3, 0, 4'b1010);
        for (int i = 0; i < 4; i++) step("shr_zero", 1, 2'd2, 0, 4'h0);
        chk("shr_last_sout", 32'(a_sout), 32'h1);
        chk("shr_word_valid", 32'(a_wv), 32'h1);

        // Mid-word load restarts the word count.
        step("pre_load_a", 1, 2'd1, 1, 4'h0);
        step("pre_load_b", 1, 2'd2, 0, 4'h0);
        step("load_0110", 1, 2'd3, 0, 4'b0110);
        for (int i = 0; i < 4; i++) step("post_load", 1, 2'($urandom_range(1, 2)), 1'($urandom_range(0, 1)), 4'h0);

        // Stalls (en=0 and hold) interleaved within a word.
        step("stall_sh0", 1, 2'd1, 1, 4'h0);
        step("stall_en0", 0, 2'd1, 0, 4'h0);
        step("stall_sh1", 1, 2'd2, 0, 4'h0);
        step("stall_hold", 1, 2'd0, 1, 4'h0);
        step("stall_en0l", 0, 2'd3, 1, 4'h3);
        step("stall_sh2", 1, 2'd1, 1, 4'h0);
        step("stall_sh3", 1, 2'd1, 0, 4'h0);

        // Back-to-back words: eight consecutive shifts.
        for (int i = 0; i < 8; i++) step("b2b", 1, 2'd1, 1'($urandom_range(0, 1)), 4'h0);

        // Reset mid-word, then a full word must be needed again.
        step("rst_pre0", 1, 2'd1, 1, 4'h0);
        step("rst_pre1", 1, 2'd1, 1, 4'h0);
        async_reset("rst_mid");
        for (int i = 0; i < 4; i++) step("post_rst", 1, 2'd1, 1, 4'h0);

        // Pattern 1111 appears after a load of 0111 and one left shift of 1.
        step("load_0111", 1, 2'd3, 0, 4'b0111);
        step("to_1111", 1, 2'd1, 1, 4'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", $urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 99) == 0) begin
                a_pat = 4'($urandom_range(0, 15));
                b_pat = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 149) == 0) async_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/shift_reg_lanes.md
# shift_reg_lanes

Parametrised multi-lane shift register: generalises the fixed 4-bit serial-in shift register to WIDTH bits per lane and LANES parallel lanes. It adds a bidirectional shift, parallel load, hold and a serial-out bit, plus a shared word counter that pulses when a full word has been shifted in. It sits between serial front-end logic and word-wide consumers.

## Interface
- WIDTH, 4, bits per lane (≥2)
- LANES, 1, number of independent lanes (≥1)
- Clock  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- en  input  1  global enable; low = everything holds, word_valid low
- mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
- d  input  LANES  serial input, bit l feeds lane l
- load_data  input  LANES*WIDTH  parallel load value, lane l at [l*WIDTH +: WIDTH]
- out  output  LANES*WIDTH  lane registers, same packing as load_data
- sout  output  LANES  registered bit most recently shifted out of each lane
- word_valid  output  1  one-cycle pulse when the WIDTH-th shift of a word completes
- pattern  input  WIDTH  compare value (SHREG_DETECT_EN only)
- match  output  LANES  lane equals pattern (SHREG_DETECT_EN only)

## Operation
- Reset low (any time, asynchronous): out = 0, sout = 0, word_valid = 0, counter = 0, match = 0 (match = 1 when pattern == 0 after the first Clock edge following deassertion).
- All lanes obey the same en/mode each cycle; only d and load_data differ per lane.
- en=1, mode 01: lane <= {lane[WIDTH-2:0], d[l]}; sout[l] <= old lane[WIDTH-1].
- en=1, mode 10: lane <= {d[l], lane[WIDTH-1:1]}; sout[l] <= old lane[0].
- en=1, mode 11: lane <= load_data lane; sout unchanged; counter <= 0; no word_valid.
- en=1, mode 00, or en=0: lane, sout, counter unchanged.
- Counter: width $clog2(WIDTH+1); increments on every enabled shift (01 or 10, direction may change mid-word). When an enabled shift takes it from WIDTH-1 to WIDTH, it stores 0 instead and word_valid is high in the following cycle only.
- word_valid is 0 in every cycle that did not complete a word, including hold, load and en=0 cycles.

## Timing
- Single-cycle latency: the effect of the inputs sampled at edge k is visible on out/sout/word_valid after edge k.
- A bit entering at edge k reaches the opposite end of the lane after edge k+WIDTH-1 and appears on sout after edge k+WIDTH.
- word_valid is asserted in the same cycle as out holding the completed word.
- Back-to-back words: word_valid pulses every WIDTH enabled shifts with no dead cycle.
- Reset deassertion: the first state change occurs at the first Clock rising edge after Reset goes high.

## Configuration
- SHREG_DETECT_EN defined: pattern/match ports exist; match[l] is registered, updated every edge to (next lane value == pattern), so it is aligned with out; reset 0.
- Not defined: pattern/match ports and compare logic are absent; all other behaviour is identical.

## Structure
- Package shift_reg_pkg: mode encodings MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_LOAD=2'b11, and a mode typedef.
- Sub-module shift_reg_lane: one lane register, its sout and optional match; instantiated LANES times by generate. The word counter and word_valid live in the top level.

## Test plan
- WIDTH=4, LANES=1: Reset low 25 ns, then mode 01, d=0 for 2 cycles, then d=1 -> out 0001, 0011, 0111, 1111; word_valid pulses after the 4th shift.
- Load 4'b1010, then mode 10 with d=0 for 4 cycles -> out 0101, 0010, 0001, 0000; sout 0, 1, 0, 1; word_valid after the 4th shift only.
- Mid-word load: 2 shifts, load 4'b0110, then 4 shifts -> no word_valid until the 4th post-load shift.
- en=0 and mode 00 cycles interleaved in a word -> out, sout and counter frozen; word_valid delayed by exactly the number of stalled cycles.
- LANES=3, WIDTH=8: distinct d per lane over 8 shifts -> each lane equals its own serial stream; single shared word_valid.
- Reset asserted mid-word (after 2 shifts) -> out and sout 0 immediately; next word needs the full WIDTH shifts. With SHREG_DETECT_EN and pattern=4'b1111: match rises in the same cycle out=1111.
